write_channel_arbiter: RTL

//  Shares one IOb write port (the AXI write-channel frontend) between N_REQ
//  IOb write requesters, for example the cache write buffer and a DMA engine.

---
 rtl/write_channel_arbiter_if.sv | 33 +++
 rtl/write_channel_arbiter.sv | 127 ++++++++++++
 2 files changed

// File: rtl/write_channel_arbiter_if.sv
// rtl/write_channel_arbiter_if.sv - request/downstream bundle for write_channel_arbiter
interface write_channel_arbiter_if #(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int NBYTES = DATA_W / 8,
    parameter int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
);
    logic [N_REQ-1:0]        s_valid;
    logic [N_REQ*ADDR_W-1:0] s_addr;
    logic [N_REQ*DATA_W-1:0] s_wdata;
    logic [N_REQ*NBYTES-1:0] s_wstrb;
    logic [N_REQ-1:0]        s_ready;
    logic                    m_valid;
    logic [ADDR_W-1:0]       m_addr;
    logic [DATA_W-1:0]       m_wdata;
    logic [NBYTES-1:0]       m_wstrb;
    logic                    m_ready;
    logic [IDX_W-1:0]        gnt_idx;
    logic                    busy;

    // Requesters plus downstream responder (environment side)
    modport master (
        output s_valid, s_addr, s_wdata, s_wstrb, m_ready,
        input  s_ready, m_valid, m_addr, m_wdata, m_wstrb, gnt_idx, busy
    );

    // Arbiter side
    modport slave (
        input  s_valid, s_addr, s_wdata, s_wstrb, m_ready,
        output s_ready, m_valid, m_addr, m_wdata, m_wstrb, gnt_idx, busy
    );
endinterface

// File: rtl/write_channel_arbiter.sv
// rtl/write_channel_arbiter.sv - N-way IOb write arbiter; WR_ARB_FIXED_PRIO_EN selects fixed priority
module write_channel_arbiter #(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int NBYTES = DATA_W / 8,
    parameter int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    write_channel_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IDX_W-1:0]  r_gnt;
    logic [IDX_W-1:0]  w_win;
    logic              w_any;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [NBYTES-1:0] r_wstrb;
    logic              w_m_valid;
    logic              w_busy;
    logic [N_REQ-1:0]  w_s_ready;

    assign w_any = |bus.s_valid;

`ifdef WR_ARB_FIXED_PRIO_EN
    // Fixed priority: descending scan so the lowest asserted index is written last
    always_comb begin
        w_win = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (bus.s_valid[i]) w_win = IDX_W'(i);
        end
    end
`else
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_ptr_nxt;
    int               w_idx;

    // Round-robin: scan ptr, ptr+1, ... in reverse so the first index in scan order wins
    always_comb begin
        w_win = '0;
        w_idx = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= N_REQ) w_idx = w_idx - N_REQ;
            if (bus.s_valid[w_idx]) w_win = IDX_W'(w_idx);
        end
    end

    assign w_ptr_nxt = (r_gnt == IDX_W'(N_REQ - 1)) ? '0 : r_gnt + 1'b1;

    // Priority pointer moves past the winner once its response is returned
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (r_state == ST_RESP) begin
            r_ptr <= w_ptr_nxt;
        end
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and state-decoded outputs; m_valid never looks at inputs
    always_comb begin
        w_state_nxt = r_state;
        w_m_valid   = 1'b0;
        w_busy      = 1'b1;
        w_s_ready   = '0;
        case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
                if (w_any) w_state_nxt = ST_XFER;
            end
            ST_XFER: begin
                w_m_valid = 1'b1;
                if (bus.m_ready) w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                w_s_ready[r_gnt] = 1'b1;
                w_state_nxt      = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Payload and winner are captured only when a grant is made from IDLE
    always_ff @(posedge clk) begin
        if (reset) begin
            r_gnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
        end else if (r_state == ST_IDLE && w_any) begin
            r_gnt   <= w_win;
            r_addr  <= bus.s_addr[w_win*ADDR_W +: ADDR_W];
            r_wdata <= bus.s_wdata[w_win*DATA_W +: DATA_W];
            r_wstrb <= bus.s_wstrb[w_win*NBYTES +: NBYTES];
        end
    end

    assign bus.m_valid = w_m_valid;
    assign bus.m_addr  = r_addr;
    assign bus.m_wdata = r_wdata;
    assign bus.m_wstrb = r_wstrb;
    assign bus.s_ready = w_s_ready;
    assign bus.gnt_idx = r_gnt;
    assign bus.busy    = w_busy;

endmodule
